// File: rtl/as_gpio_slave.sv
// as_gpio_slave: memory-mapped GPIO responder for the core's GPIO bus.
// Decodes single-cycle cs/we/address accesses into the DIR, OUT, RESULT,
// EDGE and IRQEN registers and returns registered read data one cycle
// later. The external pins are synchronized in two stages, and rising
// edges are captured into sticky flags that can raise a level interrupt.
module as_gpio_slave #(
   parameter int                  nr_gpios        = 8,
   parameter int                  gpio_addr_width = 8,
   parameter logic [nr_gpios-1:0] id_value        = 8'h37
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       cs_i,
   input  logic                       we_i,
   input  logic [gpio_addr_width-1:0] gpioAddr_i,
   input  logic [nr_gpios-1:0]        gpio_i,
   output logic [nr_gpios-1:0]        rdata_o,
   output logic                       rvalid_o,
   output logic                       err_o,
   input  logic [nr_gpios-1:0]        pins_i,
   output logic [nr_gpios-1:0]        pins_o,
   output logic [nr_gpios-1:0]        pins_oe_o,
   output logic [nr_gpios-1:0]        result_o,
   output logic                       result_stb_o,
   output logic                       irq_o
);

   // Register word addresses; every address from addr_first_unmapped up
   // answers with an error pulse.
   localparam logic [gpio_addr_width-1:0] addr_id             = gpio_addr_width'(0);
   localparam logic [gpio_addr_width-1:0] addr_dir            = gpio_addr_width'(1);
   localparam logic [gpio_addr_width-1:0] addr_out            = gpio_addr_width'(2);
   localparam logic [gpio_addr_width-1:0] addr_in             = gpio_addr_width'(3);
   localparam logic [gpio_addr_width-1:0] addr_result         = gpio_addr_width'(4);
   localparam logic [gpio_addr_width-1:0] addr_edge           = gpio_addr_width'(5);
   localparam logic [gpio_addr_width-1:0] addr_irqen          = gpio_addr_width'(6);
   localparam logic [gpio_addr_width-1:0] addr_first_unmapped = gpio_addr_width'(7);

   // Architectural registers
   logic [nr_gpios-1:0] dir_q;
   logic [nr_gpios-1:0] out_q;
   logic [nr_gpios-1:0] result_q;
   logic [nr_gpios-1:0] edge_q;
   logic [nr_gpios-1:0] irqen_q;

   // Input synchronizer chain: sync2_q is the IN register, prev_q its
   // one-cycle-old copy used for rising-edge detection.
   logic [nr_gpios-1:0] sync1_q;
   logic [nr_gpios-1:0] sync2_q;
   logic [nr_gpios-1:0] prev_q;

   // Bus response registers
   logic [nr_gpios-1:0] rdata_q;
   logic                rvalid_q;
   logic                err_q;
   logic                result_stb_q;
   logic                irq_q;

   // Decoded bus strobes
   logic                rd;
   logic                wr;
   logic                unmapped;
   logic                wr_dir;
   logic                wr_out;
   logic                wr_result;
   logic                wr_edge;
   logic                wr_irqen;

   // Next-state values shared by the EDGE, IRQEN and interrupt registers
   logic [nr_gpios-1:0] rise;
   logic [nr_gpios-1:0] edge_clr;
   logic [nr_gpios-1:0] edge_d;
   logic [nr_gpios-1:0] irqen_d;
   logic [nr_gpios-1:0] read_mux;

   // Access decode: one strobe per writable register, ID and IN writes
   // fall through without effect.
   always_comb begin
      rd        = cs_i & ~we_i;
      wr        = cs_i & we_i;
      unmapped  = (gpioAddr_i >= addr_first_unmapped);
      wr_dir    = wr && (gpioAddr_i == addr_dir);
      wr_out    = wr && (gpioAddr_i == addr_out);
      wr_result = wr && (gpioAddr_i == addr_result);
      wr_edge   = wr && (gpioAddr_i == addr_edge);
      wr_irqen  = wr && (gpioAddr_i == addr_irqen);
   end

   // Sticky edge flags and interrupt enables as they will be after this
   // edge; the interrupt is computed from these so that a clear or an
   // enable is reflected on irq_o in the very next cycle. A new edge is
   // OR-ed in after the clear so that set wins over a simultaneous W1C.
   always_comb begin
      rise     = sync2_q & ~prev_q;
      edge_clr = wr_edge ? gpio_i : '0;
      edge_d   = (edge_q & ~edge_clr) | rise;
      irqen_d  = wr_irqen ? gpio_i : irqen_q;
   end

   // Read data selection for the addressed register
   always_comb begin
      // NOTE: assigning a default before the case keeps this purely
      // combinational; a missing path would otherwise infer a latch.
      read_mux = '0;
      case (gpioAddr_i)
         addr_id:     read_mux = id_value;
         addr_dir:    read_mux = dir_q;
         addr_out:    read_mux = out_q;
         addr_in:     read_mux = sync2_q;
         addr_result: read_mux = result_q;
         addr_edge:   read_mux = edge_q;
         addr_irqen:  read_mux = irqen_q;
         default:     read_mux = '0;
      endcase
   end

   // Writable registers; reset wins over a coincident bus write
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of block order.
      if (rst_i) begin
         dir_q    <= '0;
         out_q    <= '0;
         result_q <= '0;
         edge_q   <= '0;
         irqen_q  <= '0;
      end else begin
         if (wr_dir)    dir_q    <= gpio_i;
         if (wr_out)    out_q    <= gpio_i;
         if (wr_result) result_q <= gpio_i;
         edge_q  <= edge_d;
         irqen_q <= irqen_d;
      end
   end

   // Two-stage synchronizer plus the previous-sample stage for edge detect
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= pins_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Bus response: read data held between reads, single-cycle pulses
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q      <= '0;
         rvalid_q     <= 1'b0;
         err_q        <= 1'b0;
         result_stb_q <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         if (rd) rdata_q <= read_mux;
         rvalid_q     <= rd;
         err_q        <= cs_i & unmapped;
         result_stb_q <= wr_result;
         irq_q        <= |(edge_d & irqen_d);
      end
   end

   assign rdata_o      = rdata_q;
   assign rvalid_o     = rvalid_q;
   assign err_o        = err_q;
   assign pins_o       = out_q & dir_q;
   assign pins_oe_o    = dir_q;
   assign result_o     = result_q;
   assign result_stb_o = result_stb_q;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_as_gpio_slave.sv
// Testbench for as_gpio_slave. A stimulus process drives directed and
// random bus cycles and pin changes, advances a behavioural model of the
// register map at every clock edge and queues the outputs the block must
// show after that edge. A monitor on the falling edge pops one expected
// snapshot per cycle and compares it with the DUT outputs.
module tb_as_gpio_slave;

   logic       clk;
   logic       rst;
   logic       cs;
   logic       we;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] pins;

   logic [7:0] rdata;
   logic       rvalid;
   logic       err;
   logic [7:0] pins_out;
   logic [7:0] pins_oe;
   logic [7:0] result;
   logic       result_stb;
   logic       irq;

   int tests = 0;
   int fails = 0;

   as_gpio_slave #(
      .nr_gpios        (8),
      .gpio_addr_width (8),
      .id_value        (8'h37)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cs_i         (cs),
      .we_i         (we),
      .gpioAddr_i   (addr),
      .gpio_i       (wdata),
      .rdata_o      (rdata),
      .rvalid_o     (rvalid),
      .err_o        (err),
      .pins_i       (pins),
      .pins_o       (pins_out),
      .pins_oe_o    (pins_oe),
      .result_o     (result),
      .result_stb_o (result_stb),
      .irq_o        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected DUT outputs for the cycle following one clock edge
   typedef struct {
      logic [7:0] rdata;
      logic       rvalid;
      logic       err;
      logic [7:0] pins_out;
      logic [7:0] pins_oe;
      logic [7:0] result;
      logic       stb;
      logic       irq;
   } snap_t;

   snap_t exp_q[$];
   snap_t mon_e;

   // Reference model state: register contents plus the pin values sampled
   // at the last three clock edges (s1 newest). The IN register shows the
   // pins as sampled two edges back; a rising edge is flagged once that
   // value is 1 while the sample one edge older still was 0.
   logic [7:0] m_dir, m_out, m_res, m_edge, m_irqen, m_rdata;
   logic       m_rvalid, m_err, m_stb, m_irq;
   logic [7:0] s1, s2, s3;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %02h, expected %02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs present at it
   function automatic void model_step();
      logic [7:0] rd_val;
      logic [7:0] clr;
      logic [7:0] rising;
      if (rst) begin
         m_dir = 0; m_out = 0; m_res = 0; m_edge = 0; m_irqen = 0; m_rdata = 0;
         m_rvalid = 0; m_err = 0; m_stb = 0; m_irq = 0;
         s1 = 0; s2 = 0; s3 = 0;
         return;
      end
      rising = s2 & ~s3;
      case (addr)
         8'd0:    rd_val = 8'h37;
         8'd1:    rd_val = m_dir;
         8'd2:    rd_val = m_out;
         8'd3:    rd_val = s2;
         8'd4:    rd_val = m_res;
         8'd5:    rd_val = m_edge;
         8'd6:    rd_val = m_irqen;
         default: rd_val = 8'h00;
      endcase
      m_rvalid = cs && !we;
      if (m_rvalid) m_rdata = rd_val;
      m_err = cs && (addr > 8'd6);
      m_stb = cs && we && (addr == 8'd4);
      clr   = 0;
      if (cs && we) begin
         case (addr)
            8'd1: m_dir   = wdata;
            8'd2: m_out   = wdata;
            8'd4: m_res   = wdata;
            8'd5: clr     = wdata;
            8'd6: m_irqen = wdata;
            default: ;
         endcase
      end
      m_edge = (m_edge & ~clr) | rising;
      m_irq  = (m_edge & m_irqen) != 0;
      s3 = s2; s2 = s1; s1 = pins;
   endfunction

   // One clock edge: update the model and queue what the DUT must show
   task automatic tick();
      snap_t e;
      @(posedge clk);
      model_step();
      e.rdata    = m_rdata;
      e.rvalid   = m_rvalid;
      e.err      = m_err;
      e.pins_out = m_out & m_dir;
      e.pins_oe  = m_dir;
      e.result   = m_res;
      e.stb      = m_stb;
      e.irq      = m_irq;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      cs = 1'b1; we = 1'b1; addr = a; wdata = d;
      tick();
   endtask

   task automatic bus_read(input logic [7:0] a);
      cs = 1'b1; we = 1'b0; addr = a; wdata = 8'($urandom);
      tick();
   endtask

   // No access: the other bus inputs carry junk that must be ignored
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cs = 1'b0; we = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
         tick();
      end
   endtask

   // Monitor: compare every DUT output against the queued expectation
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("rvalid",     8'(rvalid),     8'(mon_e.rvalid));
         check("rdata",      rdata,          mon_e.rdata);
         check("err",        8'(err),        8'(mon_e.err));
         check("pins_o",     pins_out,       mon_e.pins_out);
         check("pins_oe",    pins_oe,        mon_e.pins_oe);
         check("result",     result,         mon_e.result);
         check("result_stb", 8'(result_stb), 8'(mon_e.stb));
         check("irq",        8'(irq),        8'(mon_e.irq));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00; pins = 8'h00;

      // Reset held for 10 cycles, then the ID read
      idle(10);
      rst = 1'b0;
      bus_read(8'd0);
      idle(2);

      // Output path and readback
      bus_write(8'd1, 8'h0F);
      bus_write(8'd2, 8'hFF);
      bus_read(8'd1);
      bus_read(8'd2);
      idle(1);

      // RESULT strobe, including a rewrite of the same value
      bus_write(8'd4, 8'd2);
      bus_write(8'd4, 8'd0);
      idle(1);
      bus_write(8'd4, 8'd55);
      bus_write(8'd4, 8'd55);
      idle(1);

      // Rising edge on pin 0 with its interrupt enabled, then W1C
      bus_write(8'd6, 8'h01);
      pins = 8'h01;
      idle(1);
      bus_read(8'd3);
      idle(3);
      bus_read(8'd5);
      bus_write(8'd5, 8'h01);
      bus_read(8'd5);

      // W1C in the same cycle a new edge is captured: the flag survives
      pins = 8'h00;
      idle(4);
      pins = 8'h01;
      idle(2);
      bus_write(8'd5, 8'h01);
      bus_read(8'd5);
      bus_write(8'd5, 8'hFF);

      // Enabling IRQEN on an already pending flag raises irq immediately
      bus_write(8'd6, 8'h00);
      pins = 8'h03;
      idle(4);
      bus_write(8'd6, 8'h02);
      bus_write(8'd5, 8'h02);
      idle(1);

      // Unmapped accesses
      bus_write(8'd9, 8'hAA);
      bus_read(8'd9);
      bus_read(8'd1);
      bus_read(8'd7);
      bus_write(8'd0, 8'h55);
      bus_read(8'd0);

      // Reset mid-operation, coincident with a write to OUT
      bus_write(8'd2, 8'h5A);
      bus_write(8'd1, 8'hF0);
      bus_write(8'd6, 8'hFF);
      pins = 8'hF0;
      idle(4);
      rst = 1'b1;
      bus_write(8'd2, 8'h33);
      rst = 1'b0;
      bus_read(8'd2);
      bus_read(8'd1);
      bus_read(8'd5);
      bus_read(8'd6);
      idle(1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) pins = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else if ($urandom_range(0, 1) == 0) begin
            bus_write(8'($urandom_range(0, 9)), 8'($urandom));
         end else begin
            bus_read(8'($urandom_range(0, 9)));
         end
      end
      rst = 1'b0;
      idle(1);

      @(negedge clk);
      #1;
      check("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/as_gpio_slave.md
# as_gpio_slave

Memory-mapped GPIO responder on the core's GPIO bus. It decodes `cs`/address/data write cycles from the RV64I core into output, direction and result registers, and returns read data for the ID, input and edge-status registers. Inputs from external pins pass through a two-stage synchronizer and rising-edge capture logic that can raise an interrupt. It sits between the core's GPIO port and the pads/bench inside the memory top level.

## Interface
Parameters:
- `nr_gpios`, 8: pin count; also the width of every register and of the data bus.
- `gpio_addr_width`, 8: register address width.
- `id_value`, 8'h37: constant returned by the ID register.

Ports:
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `cs_i`  in  1  bus cycle valid, one cycle per access.
- `we_i`  in  1  1 = write, 0 = read; sampled with `cs_i`.
- `gpioAddr_i`  in  `gpio_addr_width`  register address.
- `gpio_i`  in  `nr_gpios`  write data.
- `rdata_o`  out  `nr_gpios`  read data.
- `rvalid_o`  out  1  read data valid, single-cycle pulse.
- `err_o`  out  1  unmapped-address pulse.
- `pins_i`  in  `nr_gpios`  asynchronous external inputs.
- `pins_o`  out  `nr_gpios`  pad output values.
- `pins_oe_o`  out  `nr_gpios`  pad output enables (1 = drive).
- `result_o`  out  `nr_gpios`  last value written to RESULT.
- `result_stb_o`  out  1  pulse marking a RESULT write.
- `irq_o`  out  1  level interrupt.

## Operation
Register map (word address):
- 0 ID, read-only: `id_value`. Writes are ignored, with no error.
- 1 DIR, read/write: drives `pins_oe_o` directly.
- 2 OUT, read/write: `pins_o` = OUT & DIR. Bits with DIR=0 output 0.
- 3 IN, read-only: synchronized pin values.
- 4 RESULT, read/write: value is `result_o`.
  - A write, including a rewrite of the same value, pulses `result_stb_o`.
  - Values 0 and 2 are status codes; 55 is the pass code. The block does not interpret them.
- 5 EDGE, read / write-1-to-clear: sticky rising-edge flags per pin.
- 6 IRQEN, read/write: per-pin interrupt enable.
- 7 and above: unmapped.
  - Reads return 0 with `rvalid_o`=1.
  - Writes are ignored.
  - Both reads and writes pulse `err_o`.

Access rules:
- Writes (`cs_i`=1, `we_i`=1) update the target register at the same clock edge.
- Reads (`cs_i`=1, `we_i`=0) register `rdata_o` at that edge. `rdata_o` holds its value until the next read.
- No access when `cs_i`=0. `we_i`, `gpioAddr_i` and `gpio_i` are don't-care.

Input path:
- `pins_i` goes through `sync1` → `sync2` (IN register) → `prev`.
- The edge for bit k is `sync2[k] & ~prev[k]`.
- EDGE next = (EDGE & ~clr) | edge.
  - `clr` is `gpio_i` on a write to address 5, else 0.
  - A set and a clear on the same bit in the same cycle: set wins.
- `irq_o` is registered: `irq_o` next = |(EDGE next & IRQEN next).

## Timing
- Reset (`rst_i`=1 at a rising edge):
  - DIR, OUT, RESULT, EDGE, IRQEN, sync stages and `prev` clear to 0.
  - `rdata_o`, `rvalid_o`, `err_o`, `result_stb_o`, `irq_o`, `pins_o` and `pins_oe_o` are all 0.
- Reset dominates a bus cycle in the same clock: that access is dropped and nothing is written.
- Read latency is 1 cycle. `cs_i` sampled at edge n → `rdata_o`/`rvalid_o` valid after edge n, for cycle n+1.
- Back-to-back accesses are allowed every cycle. There is no wait state and no back-pressure.
- A read of a register written in the previous cycle returns the new value.
- A write to OUT or DIR at edge n appears on `pins_o`/`pins_oe_o` after edge n.
- RESULT write at edge n: `result_o` updates after edge n. `result_stb_o` is high for exactly cycle n+1.
- A `pins_i` change that is stable before edge n:
  - IN shows it after edge n+1.
  - The EDGE bit sets after edge n+2.
  - `irq_o` rises after edge n+2, provided IRQEN is set.
- Clearing the last pending enabled EDGE bit at edge n drops `irq_o` after edge n.
- Enabling IRQEN on a pending EDGE bit at edge n raises `irq_o` after edge n.

## Test plan
- **Reset/ID:** assert `rst_i` for 10 cycles, then read address 0 → `rdata_o`=0x37 with `rvalid_o` a one-cycle pulse. All other outputs stay 0 through reset.
- **Output path:** write DIR=0x0F, then OUT=0xFF → `pins_oe_o`=0x0F and `pins_o`=0x0F. Read back 1 → 0x0F; read back 2 → 0xFF.
- **Result strobe:** write RESULT=2, then 0, then 55 → `result_o` follows the sequence. `result_stb_o` pulses once per write, one cycle after each `cs_i`.
- **Edge and interrupt:**
  - Write IRQEN=0x01, then drive `pins_i[0]` 0→1 → IN bit 0 reads 1 two edges later. EDGE=0x01 and `irq_o`=1 three edges after the change.
  - Write 0x01 to address 5 → EDGE=0 and `irq_o`=0.
  - Repeat with W1C issued in the same cycle a new edge is detected → the flag stays 1.
- **Unmapped:** write to address 9, then read address 9 → `err_o` pulses on both accesses, `rdata_o`=0, and no register changes.
- **Reset mid-operation:** set OUT, DIR, EDGE and IRQEN to nonzero values, then assert `rst_i` for one cycle coincident with a write to OUT → all registers are 0 and the write is lost.
